pzc_baseline_restorer: RTL

- Next-generation pole-zero cancellation (PZC) stage with baseline restoration for the digitized detector pulse chain.
- Sits after the ADC front-end, ahead of the shaper/trigger logic.
- Adds over the prior stage:
  - runtime M factor, holdoff and correction mode;
  - valid-qualified samples;
  - registered, saturated output with sticky overflow;
  - an explicit correction FSM and status counters.

---
 rtl/pzc_pkg.sv | 29 ++
 rtl/pzc_sat_acc.sv | 25 ++
 rtl/pzc_baseline_restorer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pzc_pkg.sv
// Shared types and helpers for the pole-zero cancellation / baseline restorer.
package pzc_pkg;

    typedef enum logic [1:0] {
        MASKED  = 2'd0,
        HOLDOFF = 2'd1,
        ACCUM   = 2'd2,
        APPLY   = 2'd3
    } pzc_state_e;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_NEG = 2'd1;
    localparam logic [1:0] MODE_ALL = 2'd2;

    localparam int SAT_W = 64;

    // Clamp a wide signed value into the range of an nbits-wide signed number.
    function automatic logic signed [SAT_W-1:0] sat_resize(input logic signed [SAT_W-1:0] v,
                                                           input int nbits);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (nbits - 1));
        if (v > hi) return hi;
        else if (v < lo) return lo;
        else return v;
    endfunction

endpackage

// File: rtl/pzc_sat_acc.sv
// Signed add with saturation to W_OUT bits; o_sat flags that clamping occurred.
module pzc_sat_acc
    import pzc_pkg::*;
#(
    parameter int W_IN  = 41,
    parameter int W_OUT = 28
) (
    input  logic signed [W_IN-1:0]  i_a,
    input  logic signed [W_IN-1:0]  i_b,
    output logic signed [W_OUT-1:0] o_y,
    output logic                    o_sat
);

    logic signed [W_IN:0]      w_sum;
    logic signed [SAT_W-1:0]   w_ext;
    logic signed [SAT_W-1:0]   w_clamp;

    // One guard bit keeps the raw sum exact before clamping.
    assign w_sum   = W_IN'(i_a) + W_IN'(i_b) + (W_IN+1)'(0);
    assign w_ext   = SAT_W'(w_sum);
    assign w_clamp = sat_resize(w_ext, W_OUT);
    assign o_y     = w_clamp[W_OUT-1:0];
    assign o_sat   = (w_clamp != w_ext);

endmodule

// File: rtl/pzc_baseline_restorer.sv
// Pole-zero cancellation with a windowed baseline estimate that is subtracted once per window.
module pzc_baseline_restorer
    import pzc_pkg::*;
#(
    parameter int NBITS_IN   = 12,
    parameter int NBITS_OUT  = 28,
    parameter int NBITS_M    = 12,
    parameter int LOG2_K     = 4,
    parameter int NBITS_HOLD = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [NBITS_IN-1:0]  in_data,
    input  logic                        bt_mask,
    input  logic [NBITS_M-1:0]          m_factor,
    input  logic [NBITS_HOLD-1:0]       holdoff,
    input  logic [1:0]                  mode,
    input  logic                        clr_ovf,
    output logic                        out_valid,
    output logic signed [NBITS_OUT-1:0] out_data,
    output logic                        ovf,
    output logic [15:0]                 corr_count,
    output logic [1:0]                  state_o
);

    localparam int W  = NBITS_OUT + NBITS_M + 1;
    localparam int SW = NBITS_OUT + LOG2_K + 1;
    localparam int NW = LOG2_K + 1;
    localparam logic [NW-1:0] N_FULL = NW'(2 ** LOG2_K);

    pzc_state_e                  r_state, w_state_nx;
    logic signed [NBITS_OUT-1:0] r_acc, r_out;
    logic signed [SW-1:0]        r_sum, w_sum_nx, w_sum_add;
    logic signed [SW-1:0]        r_corr, w_corr_nx;
    logic [NW-1:0]               r_n, w_n_nx, w_n_inc;
    logic [NBITS_HOLD-1:0]       r_hold_cnt, w_hold_nx, w_hold_inc;
    logic [15:0]                 r_corr_count, w_cc_nx;
    logic                        r_out_valid, r_ovf;

    logic signed [W-1:0]         w_x, w_acc, w_corr, w_m, w_mx, w_base, w_pz;
    logic signed [NBITS_OUT-1:0] w_acc_nx, w_pz_sat;
    logic                        w_acc_ovf, w_pz_ovf, w_qual;

    // A masked sample discards any pending correction, so it never reaches the datapath.
    assign w_x    = W'(in_data);
    assign w_acc  = W'(r_acc);
    assign w_corr = bt_mask ? '0 : W'(r_corr);
    assign w_m    = W'(signed'({1'b0, m_factor}));
    assign w_mx   = w_x * w_m;
    assign w_base = w_x + w_acc - w_corr;
    assign w_pz   = w_base + w_mx;

    pzc_sat_acc #(.W_IN(W), .W_OUT(NBITS_OUT)) u_acc_sat (
        .i_a   (w_base),
        .i_b   ('0),
        .o_y   (w_acc_nx),
        .o_sat (w_acc_ovf)
    );

    pzc_sat_acc #(.W_IN(W), .W_OUT(NBITS_OUT)) u_out_sat (
        .i_a   (w_base),
        .i_b   (w_mx),
        .o_y   (w_pz_sat),
        .o_sat (w_pz_ovf)
    );

    assign w_qual     = ((mode == MODE_NEG) && w_pz[W-1]) || (mode == MODE_ALL);
    assign w_sum_add  = r_sum + SW'(w_pz);
    assign w_n_inc    = r_n + NW'(1);
    assign w_hold_inc = r_hold_cnt + NBITS_HOLD'(1);

    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold_cnt;
        w_sum_nx   = r_sum;
        w_n_nx     = r_n;
        w_corr_nx  = r_corr;
        w_cc_nx    = r_corr_count;
        if (in_valid) begin
            if (bt_mask) begin
                w_state_nx = MASKED;
                w_hold_nx  = '0;
                w_sum_nx   = '0;
                w_n_nx     = '0;
                w_corr_nx  = '0;
            end else begin
                case (r_state)
                    MASKED: begin
                        w_hold_nx  = NBITS_HOLD'(1);
                        w_state_nx = (NBITS_HOLD'(1) >= holdoff) ? ACCUM : HOLDOFF;
                    end
                    HOLDOFF: begin
                        w_hold_nx = w_hold_inc;
                        if (w_hold_inc >= holdoff) w_state_nx = ACCUM;
                    end
                    ACCUM: begin
                        if (w_qual) begin
                            w_sum_nx = w_sum_add;
                            w_n_nx   = w_n_inc;
                            if (w_n_inc == N_FULL) begin
                                w_corr_nx  = w_sum_add >>> LOG2_K;
                                w_state_nx = APPLY;
                            end
                        end
                    end
                    APPLY: begin
                        w_corr_nx  = '0;
                        w_sum_nx   = '0;
                        w_n_nx     = '0;
                        w_cc_nx    = (r_corr_count == 16'hFFFF) ? r_corr_count : r_corr_count + 16'd1;
                        w_state_nx = ACCUM;
                    end
                    default: w_state_nx = MASKED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= MASKED;
            r_acc        <= '0;
            r_out        <= '0;
            r_sum        <= '0;
            r_corr       <= '0;
            r_n          <= '0;
            r_hold_cnt   <= '0;
            r_corr_count <= '0;
            r_out_valid  <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_state      <= w_state_nx;
                r_acc        <= w_acc_nx;
                r_out        <= w_pz_sat;
                r_sum        <= w_sum_nx;
                r_corr       <= w_corr_nx;
                r_n          <= w_n_nx;
                r_hold_cnt   <= w_hold_nx;
                r_corr_count <= w_cc_nx;
            end
            // A saturation in the same cycle wins over a clear request.
            if (in_valid && (w_acc_ovf || w_pz_ovf)) r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out;
    assign ovf        = r_ovf;
    assign corr_count = r_corr_count;
    assign state_o    = r_state;

endmodule
